// File: rtl/arith_pkg.sv
// Shared types and sizing helpers for the serial arithmetic datapath.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SUB_WIDTH = 8;
    localparam int CNT_W     = $clog2(SUB_WIDTH);

    // Counter width for an arbitrary operand width, never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_sub8_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, bout = borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub8.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Optional signed overflow output is enabled with SERIAL_SUB_OVF_EN.
module serial_sub8
    import arith_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] sa_reg, sb_reg;
    logic [WIDTH-2:0] sd_reg;
    logic             br_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_reg;

    logic             bit_d, bit_bout;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] diff_full;

    full_subtractor u_cell (
        .x    (sa_reg[0]),
        .y    (sb_reg[0]),
        .bin  (br_reg),
        .d    (bit_d),
        .bout (bit_bout)
    );

    assign last_bit  = (cnt_reg == CW'(WIDTH - 1));
    assign accept    = (state_reg == IDLE) && start;
    assign diff_full = {bit_d, sd_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)     state_next = BUSY;
            BUSY:    if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_reg != IDLE);
        out_valid = (state_reg == DONE);
    end

    // Serial datapath; the visible result only changes on the last bit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            sa_reg     <= '0;
            sb_reg     <= '0;
            sd_reg     <= '0;
            br_reg     <= 1'b0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
        end else if (accept) begin
            sa_reg  <= a;
            sb_reg  <= b;
            br_reg  <= borrow_in;
            cnt_reg <= '0;
        end else if (state_reg == BUSY) begin
            sa_reg  <= sa_reg >> 1;
            sb_reg  <= sb_reg >> 1;
            br_reg  <= bit_bout;
            sd_reg  <= diff_full[WIDTH-1:1];
            cnt_reg <= cnt_reg + 1'b1;
            if (last_bit) begin
                diff_reg   <= diff_full;
                borrow_reg <= bit_bout;
            end
        end
    end

    assign diff       = diff_reg;
    assign borrow_out = borrow_reg;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_reg, b_msb_reg, ovf_reg;

    // Operand MSBs are kept because the shift registers lose them during the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
        end else if ((state_reg == BUSY) && last_bit) begin
            ovf_reg <= (a_msb_reg ^ b_msb_reg) & (a_msb_reg ^ bit_d);
        end
    end

    assign overflow = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_sub8.sv
// Self-checking bench for serial_sub8: vector table, handshake corner cases, random ops.
module tb_serial_sub8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         bin;
        logic [7:0] ed;
        bit         eb;
        bit         eo;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       borrow_in;
    logic       busy, out_valid, out_ready;
    logic [7:0] diff;
    logic       borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic       overflow;
`endif

    int errors = 0;
    int checks = 0;

    serial_sub8 #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .overflow   (overflow)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for diff/borrow, signed for overflow.
    task automatic ref_sub(input logic [7:0] x, input logic [7:0] y, input bit bi,
                           output logic [7:0] d, output bit bo, output bit ov);
        int u, s;
        u  = int'(x) - int'(y) - int'(bi);
        s  = int'($signed(x)) - int'($signed(y)) - int'(bi);
        d  = u[7:0];
        bo = (u < 0);
        ov = (s < -128) || (s > 127);
    endtask

    // Called at a negedge; returns at a negedge with the DUT idle.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input bit bi,
                          input logic [7:0] ed, input bit eb, input bit eo,
                          input string tag, input int hold, input bit poke, input bit start_on_ack);
        int lat;
        a = x; b = y; borrow_in = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); borrow_in = 1'($urandom);
        check({tag, " busy"}, {31'd0, busy}, 32'd1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            if (poke && lat == 3) start = 1'b1;
            else start = 1'b0;
            @(posedge clk); #1;
            if (!out_valid) lat++;
        end
        start = 1'b0;
        check({tag, " latency"}, lat, 8);
        check({tag, " diff"}, {24'd0, diff}, {24'd0, ed});
        check({tag, " borrow_out"}, {31'd0, borrow_out}, {31'd0, eb});
`ifdef SERIAL_SUB_OVF_EN
        check({tag, " overflow"}, {31'd0, overflow}, {31'd0, eo});
`else
        if (eo) begin end
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, " hold diff"}, {24'd0, diff}, {24'd0, ed});
        end
        out_ready = 1'b1;
        if (start_on_ack) begin
            start = 1'b1; a = 8'h11; b = 8'h22; borrow_in = 1'b0;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        start = 1'b0;
        check({tag, " valid drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, " idle"}, {31'd0, busy}, 32'd0);
        check({tag, " diff kept"}, {24'd0, diff}, {24'd0, ed});
        @(negedge clk);
    endtask

    vec_t vecs[10];
    logic [7:0] rd;
    bit rb, ro;

    initial begin
        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'hA5, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hA5, 8'hA5, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[7] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
        vecs[8] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[9] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
        a = 8'h00; b = 8'h00; borrow_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset diff", {24'd0, diff}, 32'd0);
        check("reset borrow_out", {31'd0, borrow_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            ref_sub(vecs[i].a, vecs[i].b, vecs[i].bin, rd, rb, ro);
            check($sformatf("vec%0d model diff", i), {24'd0, rd}, {24'd0, vecs[i].ed});
            check($sformatf("vec%0d model borrow", i), {31'd0, rb}, {31'd0, vecs[i].eb});
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].ed, vecs[i].eb, vecs[i].eo,
                   $sformatf("vec%0d", i), 0, 1'b0, 1'b0);
            $display("vec%0d a=%02h b=%02h bin=%0d -> diff=%02h borrow=%0d", i,
                     vecs[i].a, vecs[i].b, vecs[i].bin, diff, borrow_out);
        end

        // Start while busy, stalled consumer, start coinciding with the handshake.
        ref_sub(8'h5A, 8'h33, 1'b0, rd, rb, ro);
        run_op(8'h5A, 8'h33, 1'b0, rd, rb, ro, "stall", 5, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("no second result", {30'd0, busy, out_valid}, 32'd0);
        end
        @(negedge clk);
        $display("stall/poke op diff=%02h borrow=%0d", diff, borrow_out);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] x, y;
            bit bi;
            x = 8'($urandom); y = 8'($urandom); bi = 1'($urandom);
            if (i == 0) y = x;
            ref_sub(x, y, bi, rd, rb, ro);
            run_op(x, y, bi, rd, rb, ro, $sformatf("rnd%0d", i), i % 3, 1'b0, 1'b0);
            $display("rnd%0d a=%02h b=%02h bin=%0d -> diff=%02h borrow=%0d", i, x, y, bi,
                     diff, borrow_out);
        end

        // Known nonzero result, then abandon the next op at cnt == 3.
        run_op(8'h5A, 8'h33, 1'b0, 8'h27, 1'b0, 1'b0, "pre-reset", 0, 1'b0, 1'b0);
        a = 8'hC3; b = 8'h12; borrow_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset diff", {24'd0, diff}, 32'd0);
        check("midreset borrow_out", {31'd0, borrow_out}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("midreset overflow", {31'd0, overflow}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("no partial result", {31'd0, out_valid}, 32'd0);
        end
        @(negedge clk);
        ref_sub(8'hC3, 8'h12, 1'b1, rd, rb, ro);
        run_op(8'hC3, 8'h12, 1'b1, rd, rb, ro, "post-reset", 0, 1'b0, 1'b0);
        $display("post-reset op diff=%02h borrow=%0d", diff, borrow_out);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
